tcp_rx_segment_parser: RTL and testbench
========================================

Name: tcp_rx_segment_parser

Overview:
- Upstream neighbour of the TCP server control FSM. Consumes a byte-serial received TCP segment (header, options, payload) and extracts header fields and control flags.
- Optionally filters segments on destination port.
- Presents one parsed segment at a time to the server over a valid/ready handshake. The server drives ready from its SYN/ACK port readiness.
- Discards malformed or filtered segments and counts the drops.

Parameters:
- LEN_W, 16, width of payload byte counter and payload_len_out (saturating)
- DROP_W, 16, width of drop counter (saturating)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- rx_data  in  8  segment byte, network order
- rx_valid  in  1  rx_data valid
- rx_sop  in  1  first byte of segment (qualified by rx_valid)
- rx_eop  in  1  last byte of segment (qualified by rx_valid)
- rx_ready  out  1  parser accepts byte this cycle
- filter_en  in  1  enable destination-port filter
- local_port_in  in  16  port compared against parsed dst port
- seg_valid  out  1  parsed segment available
- seg_ready  in  1  consumer accepts segment
- src_port_out  out  16  header bytes 0-1
- dst_port_out  out  16  header bytes 2-3
- seq_number_out  out  32  header bytes 4-7
- ack_number_out  out  32  header bytes 8-11
- FIN_out, SYN_out, RST_out, PSH_out, ACK_out  out  1 each  flag bits 0,1,2,3,4 of byte 13
- payload_len_out  out  LEN_W  bytes after header+options
- drop_count_out  out  DROP_W  segments discarded since reset

Behaviour:
- Reset (rst=0, async): state IDLE, all outputs 0, rx_ready=0 while asserted. Reset mid-segment abandons the segment without counting it.
- Byte transfer occurs on rx_valid && rx_ready. Byte index counter starts at 0 on the sop byte.
- States and transitions:
  - IDLE: rx_ready=1. Bytes without rx_sop are ignored (no count). An sop byte loads byte 0 and moves to HDR.
  - HDR: captures bytes 0-19 into shadow registers.
    - Byte 12: data_offset = rx_data[7:4].
    - Byte 13: flags.
    - Bytes 14-19 (window, checksum, urgent) are consumed, not stored.
    - After byte 19: go to OPT if data_offset>5, else PAYLOAD.
  - OPT: skips (data_offset*4 - 20) bytes, then goes to PAYLOAD.
  - PAYLOAD: counts bytes into payload counter. The counter saturates at 2^LEN_W-1.
  - DROP: rx_ready=1, consumes bytes until eop, then returns to IDLE.
  - HOLD: seg_valid=1, rx_ready=0. Output registers are stable.
- eop handling:
  - eop accepted in PAYLOAD, or exactly on the last header/option byte: if accepted, load output registers from shadow and enter HOLD. Also applies to eop on byte 19 with offset 5, which gives payload_len 0.
  - eop before the header/options are complete: drop, increment drop counter, go to IDLE.
- Accept checks, evaluated when eop is accepted:
  - data_offset>=5.
  - If filter_en=1: dst port == local_port_in, sampled at eop.
  - Failure of either check: drop (counter +1), go to IDLE. A data_offset<5 detected at byte 12 moves directly to DROP, with the counter incremented once, at the drop decision.
- Latency: seg_valid rises the cycle after the eop byte is accepted.
- HOLD: seg_valid && seg_ready returns to IDLE next cycle, with seg_valid low that cycle. rx_ready rises in IDLE, so there is no back-to-back acceptance in the transfer cycle.
- sop while in HDR/OPT/PAYLOAD/DROP: the current segment is dropped (counter +1 unless already counted in DROP). The sop byte is taken as byte 0 of a new segment (HDR, index 1 next).
- sop && eop on the same byte: runt; drop counter +1, go to IDLE.
- Drop counter saturates at 2^DROP_W-1. Only one increment per segment.
- Output fields hold their last accepted values after handshake; they are not cleared.

Test Plan:
1. Minimal header with SYN: src=0xC350, dst=0x1F90, seq=0x00001000, ack=0, byte12=0x50, byte13=0x02, eop on byte 19, filter_en=1, local_port_in=0x1F90 -> seg_valid next cycle; SYN_out=1, ACK/FIN/RST/PSH=0, seq_number_out=0x00001000, payload_len_out=0, drop_count_out=0.
2. Options and payload: byte12=0x80 (12 option bytes), flags 0x18, 100 payload bytes -> ACK_out=1, PSH_out=1, payload_len_out=100. seg_ready held low 5 cycles: outputs stable, rx_ready=0; after handshake, seg_valid=0.
3. Port filter: filter_en=1, local_port_in=0x0050, dst=0x1F90 -> no seg_valid, drop_count_out=1. Same segment with filter_en=0 -> accepted.
4. Runt/bad offset: eop at byte 10 -> drop_count_out=1. byte12=0x40 followed by 30 bytes -> drop_count_out=2, no seg_valid.
5. sop at payload byte 3 of segment A, new valid segment B follows -> drop_count_out=1; B delivered with its own fields.
6. Reset mid-HDR at byte 7 -> all outputs 0, drop_count_out=0; next segment parses correctly.

Source files
------------

// File: rtl/tcp_rx_segment_parser.sv
// TCP receive segment parser.
// Takes a byte-serial TCP segment and extracts the port, sequence, ack and flag
// fields. It can filter segments on destination port. Accepted segments are
// presented to the server FSM over a valid/ready handshake. Malformed or
// filtered segments are dropped and counted.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for an sop byte; non-sop bytes are ignored
// HDR      | capturing fixed header bytes 0-19
// OPT      | skipping option bytes up to data_offset*4
// PAYLOAD  | counting payload bytes until eop
// DROP     | discarding the rest of an already-counted bad segment
// HOLD     | parsed segment presented, waiting for seg_ready
module tcp_rx_segment_parser #(
    parameter int LEN_W  = 16,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_sop,
    input  logic              rx_eop,
    output logic              rx_ready,
    input  logic              filter_en,
    input  logic [15:0]       local_port_in,
    output logic              seg_valid,
    input  logic              seg_ready,
    output logic [15:0]       src_port_out,
    output logic [15:0]       dst_port_out,
    output logic [31:0]       seq_number_out,
    output logic [31:0]       ack_number_out,
    output logic              FIN_out,
    output logic              SYN_out,
    output logic              RST_out,
    output logic              PSH_out,
    output logic              ACK_out,
    output logic [LEN_W-1:0]  payload_len_out,
    output logic [DROP_W-1:0] drop_count_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_OPT,
        S_PAYLOAD,
        S_DROP,
        S_HOLD
    } state_t;

    state_t state, state_nxt;

    logic [5:0]        idx;
    logic [15:0]       src_sh;
    logic [15:0]       dst_sh;
    logic [31:0]       seq_sh;
    logic [31:0]       ack_sh;
    logic [3:0]        doff_sh;
    logic [4:0]        flags_sh;
    logic [LEN_W-1:0]  pay_cnt;
    logic [LEN_W-1:0]  pay_inc;
    logic [5:0]        opt_last;
    logic [DROP_W:0]   drop_sum;

    logic              xfer;
    logic              start;
    logic              eop_ok;
    logic              accept;
    logic [1:0]        drop_inc;

    // Ready is withheld while a parsed segment waits and while in reset.
    assign rx_ready  = rst && (state != S_HOLD);
    assign seg_valid = (state == S_HOLD);
    assign xfer      = rx_valid && rx_ready;
    assign pay_inc   = (&pay_cnt) ? pay_cnt : pay_cnt + 1'b1;
    assign opt_last  = {doff_sh, 2'b00} - 6'd1;
    assign drop_sum  = {1'b0, drop_count_out} + {{(DROP_W-1){1'b0}}, drop_inc};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode, drop decisions and segment acceptance.
    always_comb begin
        state_nxt = state;
        drop_inc  = 2'd0;
        start     = 1'b0;
        eop_ok    = 1'b0;
        accept    = 1'b0;
        if (state == S_HOLD) begin
            if (seg_ready) begin
                state_nxt = S_IDLE;
            end
        end else if (xfer) begin
            if (rx_sop) begin
                // A new sop abandons whatever segment is in flight; DROP was
                // already counted when it was entered.
                if (state == S_HDR || state == S_OPT || state == S_PAYLOAD) begin
                    drop_inc = drop_inc + 2'd1;
                end
                if (rx_eop) begin
                    drop_inc  = drop_inc + 2'd1;
                    state_nxt = S_IDLE;
                end else begin
                    start     = 1'b1;
                    state_nxt = S_HDR;
                end
            end else begin
                case (state)
                    S_HDR: begin
                        if (idx == 6'd12 && rx_data[7:4] < 4'd5) begin
                            drop_inc  = 2'd1;
                            state_nxt = rx_eop ? S_IDLE : S_DROP;
                        end else if (rx_eop) begin
                            if (idx == 6'd19 && doff_sh == 4'd5) begin
                                eop_ok = 1'b1;
                            end else begin
                                drop_inc  = 2'd1;
                                state_nxt = S_IDLE;
                            end
                        end else if (idx == 6'd19) begin
                            state_nxt = (doff_sh > 4'd5) ? S_OPT : S_PAYLOAD;
                        end
                    end
                    S_OPT: begin
                        if (rx_eop) begin
                            if (idx == opt_last) begin
                                eop_ok = 1'b1;
                            end else begin
                                drop_inc  = 2'd1;
                                state_nxt = S_IDLE;
                            end
                        end else if (idx == opt_last) begin
                            state_nxt = S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        if (rx_eop) begin
                            eop_ok = 1'b1;
                        end
                    end
                    S_DROP: begin
                        if (rx_eop) begin
                            state_nxt = S_IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
                // data_offset < 5 never reaches here; only the port filter remains.
                if (eop_ok) begin
                    if (filter_en && dst_sh != local_port_in) begin
                        drop_inc  = 2'd1;
                        state_nxt = S_IDLE;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = S_HOLD;
                    end
                end
            end
        end
    end

    // Header shadow capture, payload counting, output load and drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx             <= '0;
            src_sh          <= '0;
            dst_sh          <= '0;
            seq_sh          <= '0;
            ack_sh          <= '0;
            doff_sh         <= '0;
            flags_sh        <= '0;
            pay_cnt         <= '0;
            src_port_out    <= '0;
            dst_port_out    <= '0;
            seq_number_out  <= '0;
            ack_number_out  <= '0;
            FIN_out         <= 1'b0;
            SYN_out         <= 1'b0;
            RST_out         <= 1'b0;
            PSH_out         <= 1'b0;
            ACK_out         <= 1'b0;
            payload_len_out <= '0;
            drop_count_out  <= '0;
        end else begin
            if (start) begin
                src_sh[15:8] <= rx_data;
                idx          <= 6'd1;
                pay_cnt      <= '0;
            end else if (xfer && (state == S_HDR || state == S_OPT)) begin
                idx <= idx + 6'd1;
                case (idx)
                    6'd1:  src_sh[7:0]   <= rx_data;
                    6'd2:  dst_sh[15:8]  <= rx_data;
                    6'd3:  dst_sh[7:0]   <= rx_data;
                    6'd4:  seq_sh[31:24] <= rx_data;
                    6'd5:  seq_sh[23:16] <= rx_data;
                    6'd6:  seq_sh[15:8]  <= rx_data;
                    6'd7:  seq_sh[7:0]   <= rx_data;
                    6'd8:  ack_sh[31:24] <= rx_data;
                    6'd9:  ack_sh[23:16] <= rx_data;
                    6'd10: ack_sh[15:8]  <= rx_data;
                    6'd11: ack_sh[7:0]   <= rx_data;
                    6'd12: doff_sh       <= rx_data[7:4];
                    6'd13: flags_sh      <= rx_data[4:0];
                    default: begin
                    end
                endcase
            end else if (xfer && state == S_PAYLOAD) begin
                pay_cnt <= pay_inc;
            end

            if (accept) begin
                src_port_out    <= src_sh;
                dst_port_out    <= dst_sh;
                seq_number_out  <= seq_sh;
                ack_number_out  <= ack_sh;
                FIN_out         <= flags_sh[0];
                SYN_out         <= flags_sh[1];
                RST_out         <= flags_sh[2];
                PSH_out         <= flags_sh[3];
                ACK_out         <= flags_sh[4];
                payload_len_out <= (state == S_PAYLOAD) ? pay_inc : '0;
            end

            if (drop_inc != 2'd0) begin
                drop_count_out <= drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_tcp_rx_segment_parser.sv
// Directed bench for the TCP receive segment parser.
module tb_tcp_rx_segment_parser;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sop;
    logic        rx_eop;
    logic        rx_ready;
    logic        filter_en;
    logic [15:0] local_port_in;
    logic        seg_valid;
    logic        seg_ready;
    logic [15:0] src_port_out;
    logic [15:0] dst_port_out;
    logic [31:0] seq_number_out;
    logic [31:0] ack_number_out;
    logic        FIN_out;
    logic        SYN_out;
    logic        RST_out;
    logic        PSH_out;
    logic        ACK_out;
    logic [15:0] payload_len_out;
    logic [15:0] drop_count_out;

    int n_checks;
    int n_errors;
    logic [7:0] seg[$];

    tcp_rx_segment_parser #(.LEN_W(16), .DROP_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_sop          (rx_sop),
        .rx_eop          (rx_eop),
        .rx_ready        (rx_ready),
        .filter_en       (filter_en),
        .local_port_in   (local_port_in),
        .seg_valid       (seg_valid),
        .seg_ready       (seg_ready),
        .src_port_out    (src_port_out),
        .dst_port_out    (dst_port_out),
        .seq_number_out  (seq_number_out),
        .ack_number_out  (ack_number_out),
        .FIN_out         (FIN_out),
        .SYN_out         (SYN_out),
        .RST_out         (RST_out),
        .PSH_out         (PSH_out),
        .ACK_out         (ACK_out),
        .payload_len_out (payload_len_out),
        .drop_count_out  (drop_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic build(input logic [15:0] s, input logic [15:0] d,
                         input logic [31:0] sq, input logic [31:0] ak,
                         input logic [7:0] b12, input logic [7:0] b13,
                         input int nopt, input int npay);
        seg.delete();
        seg.push_back(s[15:8]);   seg.push_back(s[7:0]);
        seg.push_back(d[15:8]);   seg.push_back(d[7:0]);
        seg.push_back(sq[31:24]); seg.push_back(sq[23:16]);
        seg.push_back(sq[15:8]);  seg.push_back(sq[7:0]);
        seg.push_back(ak[31:24]); seg.push_back(ak[23:16]);
        seg.push_back(ak[15:8]);  seg.push_back(ak[7:0]);
        seg.push_back(b12);       seg.push_back(b13);
        for (int i = 0; i < 6; i++) seg.push_back(8'h00);
        for (int i = 0; i < nopt; i++) seg.push_back(8'h01);
        for (int i = 0; i < npay; i++) seg.push_back(i[7:0] ^ 8'h5A);
    endtask

    // Sends the first n bytes of seg; ends on the negedge after the last edge.
    task automatic send(input int n, input bit with_eop);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = seg[i];
            rx_sop   = (i == 0);
            rx_eop   = with_eop && (i == n - 1);
            for (int w = 0; w < 50 && !rx_ready; w++) @(negedge clk);
            if (!rx_ready) chk("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
            @(posedge clk);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_sop   = 1'b0;
        rx_eop   = 1'b0;
    endtask

    task automatic handshake();
        seg_ready = 1'b1;
        @(negedge clk);
        seg_ready = 1'b0;
        chk("seg_valid_after_hs", {31'd0, seg_valid}, 32'd0);
        chk("rx_ready_after_hs", {31'd0, rx_ready}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        rx_data = 8'h00; rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
        filter_en = 1'b0; local_port_in = 16'h0000; seg_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("rst_seg_valid", {31'd0, seg_valid}, 32'd0);
        chk("rst_drop", {16'd0, drop_count_out}, 32'd0);
        chk("rst_seq", seq_number_out, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_rx_ready", {31'd0, rx_ready}, 32'd1);

        // 1: minimal header, SYN, eop on byte 19
        filter_en = 1'b1; local_port_in = 16'h1F90;
        build(16'hC350, 16'h1F90, 32'h0000_1000, 32'h0, 8'h50, 8'h02, 0, 0);
        send(20, 1'b1);
        chk("t1_seg_valid", {31'd0, seg_valid}, 32'd1);
        chk("t1_src", {16'd0, src_port_out}, 32'hC350);
        chk("t1_dst", {16'd0, dst_port_out}, 32'h1F90);
        chk("t1_seq", seq_number_out, 32'h0000_1000);
        chk("t1_ack", ack_number_out, 32'h0);
        chk("t1_flags", {27'd0, ACK_out, PSH_out, RST_out, SYN_out, FIN_out}, 32'h02);
        chk("t1_len", {16'd0, payload_len_out}, 32'd0);
        chk("t1_drop", {16'd0, drop_count_out}, 32'd0);
        handshake();

        // 2: options and payload, held off for 5 cycles
        build(16'h1234, 16'h1F90, 32'hAABB_CCDD, 32'h1122_3344, 8'h80, 8'h18, 12, 100);
        send(132, 1'b1);
        for (int c = 0; c < 5; c++) begin
            chk("t2_hold_valid", {31'd0, seg_valid}, 32'd1);
            chk("t2_hold_rx_ready", {31'd0, rx_ready}, 32'd0);
            chk("t2_hold_len", {16'd0, payload_len_out}, 32'd100);
            chk("t2_hold_ack", ack_number_out, 32'h1122_3344);
            @(negedge clk);
        end
        chk("t2_flags", {27'd0, ACK_out, PSH_out, RST_out, SYN_out, FIN_out}, 32'h18);
        chk("t2_src", {16'd0, src_port_out}, 32'h1234);
        chk("t2_seq", seq_number_out, 32'hAABB_CCDD);
        handshake();
        chk("t2_len_kept", {16'd0, payload_len_out}, 32'd100);

        // 3: port filter drops, then passes with filter off
        do_reset();
        filter_en = 1'b1; local_port_in = 16'h0050;
        build(16'h0400, 16'h1F90, 32'h0000_0007, 32'h0000_0009, 8'h50, 8'h10, 0, 4);
        send(24, 1'b1);
        chk("t3_filt_valid", {31'd0, seg_valid}, 32'd0);
        chk("t3_filt_drop", {16'd0, drop_count_out}, 32'd1);
        filter_en = 1'b0;
        send(24, 1'b1);
        chk("t3_pass_valid", {31'd0, seg_valid}, 32'd1);
        chk("t3_pass_src", {16'd0, src_port_out}, 32'h0400);
        chk("t3_pass_len", {16'd0, payload_len_out}, 32'd4);
        chk("t3_pass_drop", {16'd0, drop_count_out}, 32'd1);
        handshake();

        // 4: runt at byte 10, then data_offset 4 with trailing bytes
        do_reset();
        build(16'h0101, 16'h0202, 32'h3, 32'h4, 8'h50, 8'h02, 0, 0);
        send(11, 1'b1);
        chk("t4_runt_valid", {31'd0, seg_valid}, 32'd0);
        chk("t4_runt_drop", {16'd0, drop_count_out}, 32'd1);
        build(16'h0101, 16'h0202, 32'h3, 32'h4, 8'h40, 8'h02, 0, 23);
        send(43, 1'b1);
        chk("t4_doff_valid", {31'd0, seg_valid}, 32'd0);
        chk("t4_doff_drop", {16'd0, drop_count_out}, 32'd2);
        chk("t4_doff_rx_ready", {31'd0, rx_ready}, 32'd1);

        // 5: sop in payload of A; B delivered
        do_reset();
        build(16'h1111, 16'h2222, 32'h5555_6666, 32'h7777_8888, 8'h50, 8'h10, 0, 10);
        send(23, 1'b0);
        build(16'hABCD, 16'h1F90, 32'hCAFE_BABE, 32'hDEAD_BEEF, 8'h50, 8'h11, 0, 5);
        send(25, 1'b1);
        chk("t5_valid", {31'd0, seg_valid}, 32'd1);
        chk("t5_drop", {16'd0, drop_count_out}, 32'd1);
        chk("t5_src", {16'd0, src_port_out}, 32'hABCD);
        chk("t5_seq", seq_number_out, 32'hCAFE_BABE);
        chk("t5_ack", ack_number_out, 32'hDEAD_BEEF);
        chk("t5_flags", {27'd0, ACK_out, PSH_out, RST_out, SYN_out, FIN_out}, 32'h11);
        chk("t5_len", {16'd0, payload_len_out}, 32'd5);
        handshake();

        // 6: reset mid-header at byte 7, then a clean segment
        build(16'h5555, 16'h1F90, 32'h0102_0304, 32'h0, 8'h50, 8'h04, 0, 7);
        send(8, 1'b0);
        rst = 1'b0;
        #1;
        chk("t6_rst_src", {16'd0, src_port_out}, 32'd0);
        chk("t6_rst_seq", seq_number_out, 32'd0);
        chk("t6_rst_drop", {16'd0, drop_count_out}, 32'd0);
        chk("t6_rst_len", {16'd0, payload_len_out}, 32'd0);
        chk("t6_rst_flags", {27'd0, ACK_out, PSH_out, RST_out, SYN_out, FIN_out}, 32'h0);
        chk("t6_rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        send(27, 1'b1);
        chk("t6_valid", {31'd0, seg_valid}, 32'd1);
        chk("t6_src", {16'd0, src_port_out}, 32'h5555);
        chk("t6_seq", seq_number_out, 32'h0102_0304);
        chk("t6_flags", {27'd0, ACK_out, PSH_out, RST_out, SYN_out, FIN_out}, 32'h04);
        chk("t6_len", {16'd0, payload_len_out}, 32'd7);
        chk("t6_drop", {16'd0, drop_count_out}, 32'd0);
        handshake();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
